// File: rtl/mem_dump_serializer.sv
// Snapshots the flattened data-memory image on i_start and streams it out MSB-byte-first
// over a valid/ready handshake. Optional macro MEM_DUMP_HEADER_EN prepends 0xA5 and the word count.
`timescale 1ns/1ps

module mem_dump_serializer #(
  parameter int IO_BUS_SIZE   = 32,
  parameter int MEM_ADDR_SIZE = 5,
  parameter int BYTE_SIZE     = 8
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset,
  input  logic                                        i_start,
  input  logic [(2**MEM_ADDR_SIZE)*IO_BUS_SIZE-1:0]   i_bus_debug,
  output logic [BYTE_SIZE-1:0]                        o_data,
  output logic                                        o_valid,
  input  logic                                        i_ready,
  output logic                                        o_busy,
  output logic                                        o_done
);

  localparam int WORDS = 2**MEM_ADDR_SIZE;
  localparam int IMG_W = WORDS * IO_BUS_SIZE;
  localparam int BPW   = IO_BUS_SIZE / BYTE_SIZE;
  localparam int N     = WORDS * BPW;
`ifdef MEM_DUMP_HEADER_EN
  localparam int HDR   = 2;
`else
  localparam int HDR   = 0;
`endif
  localparam int L     = N + HDR;
  localparam int CNT_W = $clog2(N) + 1;
  localparam int IDX_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_e;

  state_e               r_state, w_state_nxt;
  logic [IMG_W-1:0]     r_snap,  w_snap_nxt;
  logic [CNT_W-1:0]     r_cnt,   w_cnt_nxt;
  logic [BYTE_SIZE-1:0] w_stream [L];
  logic [IDX_W-1:0]     w_idx;
  logic                 w_xfer;

  // Stream position j maps to a fixed byte lane of the snapshot, so the output is a plain mux.
`ifdef MEM_DUMP_HEADER_EN
  localparam logic [31:0] WORDS_U = 32'(WORDS);
  assign w_stream[0] = BYTE_SIZE'(8'hA5);
  assign w_stream[1] = BYTE_SIZE'(WORDS_U[7:0]);
`endif

  for (genvar j = 0; j < N; j++) begin : g_img
    assign w_stream[HDR + j] =
      r_snap[(j / BPW) * IO_BUS_SIZE + (BPW - 1 - (j % BPW)) * BYTE_SIZE +: BYTE_SIZE];
  end

  assign w_idx  = r_cnt[IDX_W-1:0];
  assign w_xfer = o_valid && i_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_snap_nxt  = r_snap;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_snap_nxt  = i_bus_debug;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == LAST) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  // The snapshot is reset too: it is a plain register bank, and a cleared image keeps o_data defined.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_snap  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_snap  <= w_snap_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_valid = (r_state == S_SEND);
  assign o_busy  = (r_state == S_SEND);
  assign o_done  = (r_state == S_DONE);
  assign o_data  = (r_state == S_SEND) ? w_stream[w_idx] : '0;

endmodule

// File: tb/tb_mem_dump_serializer.sv
// Randomized self-checking bench for mem_dump_serializer: an expected byte queue is built
// straight from the image, then compared against the stream under various ready patterns.
`timescale 1ns/1ps

module tb_mem_dump_serializer;

  localparam int IO_BUS_SIZE   = 32;
  localparam int MEM_ADDR_SIZE = 5;
  localparam int BYTE_SIZE     = 8;
  localparam int WORDS = 2**MEM_ADDR_SIZE;
  localparam int IMG_W = WORDS * IO_BUS_SIZE;
  localparam int BPW   = IO_BUS_SIZE / 8;
`ifdef MEM_DUMP_HEADER_EN
  localparam int L = WORDS * BPW + 2;
`else
  localparam int L = WORDS * BPW;
`endif

  logic                 clk = 1'b0;
  logic                 i_reset;
  logic                 i_start;
  logic [IMG_W-1:0]     i_bus_debug;
  logic [BYTE_SIZE-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_busy;
  logic                 o_done;

  int n_checks = 0;
  int n_fail   = 0;

  mem_dump_serializer #(
    .IO_BUS_SIZE  (IO_BUS_SIZE),
    .MEM_ADDR_SIZE(MEM_ADDR_SIZE),
    .BYTE_SIZE    (BYTE_SIZE)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_bus_debug(i_bus_debug),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IMG_W-1:0] make_pattern();
    logic [IMG_W-1:0] img;
    for (int k = 0; k < WORDS; k++) img[k*32 +: 32] = 32'h11223300 | 32'(k);
    return img;
  endfunction

  function automatic logic [IMG_W-1:0] make_random();
    logic [IMG_W-1:0] img;
    for (int k = 0; k < WORDS; k++) img[k*32 +: 32] = $urandom();
    return img;
  endfunction

  // mode: 0 ready=1, 1 stall 5 cycles then ready=1, 2 random ready, 3 ready=1 with i_start at byte 40.
  // rst_after >= 0 asserts reset once that many bytes have transferred.
  task automatic run_dump(input logic [IMG_W-1:0] img, input int mode, input int rst_after);
    logic [7:0] exp_q[$];
    logic [31:0] wcount;
    int got, dones, stall;
    bit fin;
    wcount = 32'(WORDS);
`ifdef MEM_DUMP_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(wcount[7:0]);
`endif
    for (int w = 0; w < WORDS; w++)
      for (int b = BPW - 1; b >= 0; b--)
        exp_q.push_back(img[w*IO_BUS_SIZE + b*8 +: 8]);

    got = 0; dones = 0; stall = 0; fin = 1'b0;
    @(negedge clk);
    i_bus_debug = img;
    i_start     = 1'b1;
    i_ready     = 1'($urandom_range(0, 1));
    @(negedge clk);
    i_start     = 1'b0;
    i_bus_debug = '1;

    for (int cyc = 0; cyc < 8 * L && !fin; cyc++) begin
      i_start = 1'b0;
      check("busy_eq_valid", 32'(o_busy), 32'(o_valid));
      if (o_done) begin
        dones++;
        check("len_at_done", got, L);
        check("valid_at_done", 32'(o_valid), 0);
        @(negedge clk);
        check("done_one_cycle", 32'(o_done), 0);
        check("idle_after_done", 32'(o_valid), 0);
        fin = 1'b1;
      end else if (o_valid) begin
        if (got == rst_after) begin
          i_ready = 1'b0;
          i_reset = 1'b0;
          #1;
          check("rst_valid", 32'(o_valid), 0);
          check("rst_busy", 32'(o_busy), 0);
          check("rst_data", 32'(o_data), 0);
          check("rst_done", 32'(o_done), 0);
          repeat (3) begin
            @(negedge clk);
            check("rst_no_done", 32'(o_done), 0);
          end
          i_reset = 1'b1;
          return;
        end
        if (got >= L) begin
          check("overrun", got, L - 1);
          fin = 1'b1;
        end else begin
          check("byte", 32'(o_data), 32'(exp_q[got]));
          case (mode)
            1: begin
              i_ready = (stall >= 5);
              stall++;
            end
            2:       i_ready = ($urandom_range(0, 3) != 0);
            default: i_ready = 1'b1;
          endcase
          if (mode == 3 && got == 40) i_start = 1'b1;
          if (i_ready) got++;
          @(negedge clk);
        end
      end else begin
        check("valid_in_send", 32'(o_valid), 1);
        fin = 1'b1;
      end
    end
    i_start = 1'b0;
    check("done_count", dones, 1);
  endtask

  initial begin
    logic [IMG_W-1:0] pat;
    i_reset     = 1'b0;
    i_start     = 1'b0;
    i_ready     = 1'b0;
    i_bus_debug = '0;
    #1;
    check("reset_valid", 32'(o_valid), 0);
    check("reset_busy", 32'(o_busy), 0);
    check("reset_done", 32'(o_done), 0);
    check("reset_data", 32'(o_data), 0);
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check("idle_valid", 32'(o_valid), 0);

    pat = make_pattern();
    run_dump(pat, 0, -1);
    run_dump(pat, 1, -1);
    run_dump(pat, 3, -1);
    run_dump(pat, 0, 10);
    run_dump(pat, 0, -1);
    for (int i = 0; i < 4; i++) run_dump(make_random(), 2, -1);

    repeat (3) @(negedge clk);
    check("final_idle", 32'(o_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
